// File: rtl/npu_cube_acc_resolve_if.sv
`default_nettype none
// ============================================================================
// Module   : npu_cube_acc_resolve_if
// Brief    : Beat input and result output bundle for the cube accumulator.
// Revision : 1.0 - initial release
// ============================================================================
interface npu_cube_acc_resolve_if #(
  parameter int DWIN  = 19,
  parameter int DWACC = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [DWIN-1:0]  in_cay;
  logic [DWIN-1:0]  in_sum;
  logic             in_first;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [DWACC-1:0] out_data;
  logic [15:0]      out_cnt;
  logic             out_ovf;

  modport master (
    output in_valid, in_cay, in_sum, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_cnt, out_ovf
  );

  modport slave (
    input  in_valid, in_cay, in_sum, in_first, in_last, out_ready,
    output in_ready, out_valid, out_data, out_cnt, out_ovf
  );
endinterface
`default_nettype wire

// File: rtl/npu_cube_acc_resolve.sv
`default_nettype none
// ============================================================================
// Module   : npu_cube_acc_resolve
// Brief    : Resolves carry-save beats to binary (S1), then accumulates each
//            first/last framed burst into a held valid/ready result (S2).
// Revision : 1.0 - initial release
// ============================================================================
module npu_cube_acc_resolve #(
  parameter int DWIN   = 19,
  parameter int DWACC  = 32,
  parameter bit SIGNED = 1'b0,
  parameter bit SAT    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  npu_cube_acc_resolve_if.slave   bus
);

  localparam logic [15:0]      c_cnt_max  = 16'hFFFF;
  localparam logic [DWACC-1:0] c_umax     = {DWACC{1'b1}};
  localparam logic [DWACC-1:0] c_smax     = {1'b0, {(DWACC-1){1'b1}}};
  localparam logic [DWACC-1:0] c_smin     = {1'b1, {(DWACC-1){1'b0}}};

  // S1 state
  logic             r_s1_valid;
  logic [DWIN-1:0]  r_s1_res;
  logic             r_s1_first;
  logic             r_s1_last;

  // S2 accumulation state and output register
  logic [DWACC-1:0] r_acc;
  logic [15:0]      r_cnt;
  logic             r_ovf;
  logic             r_out_valid;
  logic [DWACC-1:0] r_out_data;
  logic [15:0]      r_out_cnt;
  logic             r_out_ovf;

  logic [DWIN:0]    w_csa_sum;
  logic [DWIN-1:0]  w_res;
  logic             w_unused;
  logic             w_s1_adv;
  logic             w_in_acc;
  logic [DWACC-1:0] w_ext;
  logic [DWACC-1:0] w_acc_base;
  logic [DWACC:0]   w_add;
  logic [DWACC-1:0] w_raw;
  logic             w_ovf_u;
  logic             w_ovf_s;
  logic             w_ovf_evt;
  logic [DWACC-1:0] w_acc_n;
  logic [15:0]      w_cnt_n;
  logic             w_ovf_n;

  // Carry vector carries weight 2; its top bit falls off the DWIN-bit result.
  assign w_csa_sum = {1'b0, bus.in_sum} + {bus.in_cay, 1'b0};
  assign w_res     = w_csa_sum[DWIN-1:0];
  assign w_unused  = w_csa_sum[DWIN];

  // Only a last beat can stall, and only behind an unaccepted held result.
  assign w_s1_adv     = r_s1_valid && !(r_s1_last && r_out_valid && !bus.out_ready);
  assign bus.in_ready = !r_s1_valid || w_s1_adv;
  assign w_in_acc     = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_res   <= '0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
    end else if (w_in_acc) begin
      r_s1_valid <= 1'b1;
      r_s1_res   <= w_res;
      r_s1_first <= bus.in_first;
      r_s1_last  <= bus.in_last;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  generate
    if (SIGNED) begin : g_ext_signed
      assign w_ext = {{(DWACC-DWIN){r_s1_res[DWIN-1]}}, r_s1_res};
    end else begin : g_ext_unsigned
      assign w_ext = {{(DWACC-DWIN){1'b0}}, r_s1_res};
    end
  endgenerate

  // A first beat restarts from zero, so it can never flag an overflow.
  assign w_acc_base = r_s1_first ? '0 : r_acc;
  assign w_add      = {1'b0, w_acc_base} + {1'b0, w_ext};
  assign w_raw      = w_add[DWACC-1:0];
  assign w_ovf_u    = w_add[DWACC];
  assign w_ovf_s    = (w_acc_base[DWACC-1] == w_ext[DWACC-1]) &&
                      (w_raw[DWACC-1] != w_acc_base[DWACC-1]);
  assign w_ovf_evt  = SIGNED ? w_ovf_s : w_ovf_u;

  always_comb begin
    w_acc_n = w_raw;
    if (SAT && w_ovf_evt) begin
      if (SIGNED) begin
        w_acc_n = w_ext[DWACC-1] ? c_smin : c_smax;
      end else begin
        w_acc_n = c_umax;
      end
    end
  end

  always_comb begin
    w_cnt_n = 16'd1;
    w_ovf_n = w_ovf_evt;
    if (!r_s1_first) begin
      w_cnt_n = (r_cnt == c_cnt_max) ? c_cnt_max : r_cnt + 16'd1;
      w_ovf_n = r_ovf | w_ovf_evt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_cnt   <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_s1_adv) begin
        if (r_s1_last) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_acc_n;
          r_out_cnt   <= w_cnt_n;
          r_out_ovf   <= w_ovf_n;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_ovf       <= 1'b0;
        end else begin
          r_acc <= w_acc_n;
          r_cnt <= w_cnt_n;
          r_ovf <= w_ovf_n;
        end
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_cnt   = r_out_cnt;
  assign bus.out_ovf   = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_npu_cube_acc_resolve.sv
`default_nettype none
// ============================================================================
// Module   : tb_npu_cube_acc_resolve
// Brief    : Five configurations share one beat stream; a scoreboard of
//            model results is popped on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_npu_cube_acc_resolve;

  typedef struct packed {
    logic [4:0][31:0] d;
    logic [15:0]      c;
    logic [4:0]       o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [18:0] in_cay = '0;
  logic [18:0] in_sum = '0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  int          rdy_mode = 0;

  int          errors = 0;
  int          checks = 0;
  exp_t        exp_q[$];

  // model configuration: accumulator width, signed, saturating
  int          cw[5] = '{32, 32, 20, 20, 20};
  bit          cs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  bit          cz[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  longint      m_acc[5];
  bit          m_ovf[5];
  int          m_cnt = 0;

  always #5 clk = ~clk;

  npu_cube_acc_resolve_if #(.DWIN(19), .DWACC(32)) b0 ();
  npu_cube_acc_resolve_if #(.DWIN(19), .DWACC(32)) b1 ();
  npu_cube_acc_resolve_if #(.DWIN(19), .DWACC(20)) b2 ();
  npu_cube_acc_resolve_if #(.DWIN(19), .DWACC(20)) b3 ();
  npu_cube_acc_resolve_if #(.DWIN(19), .DWACC(20)) b4 ();

  assign b0.in_valid = in_valid;  assign b0.in_cay = in_cay;  assign b0.in_sum = in_sum;
  assign b0.in_first = in_first;  assign b0.in_last = in_last; assign b0.out_ready = out_ready;
  assign b1.in_valid = in_valid;  assign b1.in_cay = in_cay;  assign b1.in_sum = in_sum;
  assign b1.in_first = in_first;  assign b1.in_last = in_last; assign b1.out_ready = out_ready;
  assign b2.in_valid = in_valid;  assign b2.in_cay = in_cay;  assign b2.in_sum = in_sum;
  assign b2.in_first = in_first;  assign b2.in_last = in_last; assign b2.out_ready = out_ready;
  assign b3.in_valid = in_valid;  assign b3.in_cay = in_cay;  assign b3.in_sum = in_sum;
  assign b3.in_first = in_first;  assign b3.in_last = in_last; assign b3.out_ready = out_ready;
  assign b4.in_valid = in_valid;  assign b4.in_cay = in_cay;  assign b4.in_sum = in_sum;
  assign b4.in_first = in_first;  assign b4.in_last = in_last; assign b4.out_ready = out_ready;

  npu_cube_acc_resolve #(.DWIN(19), .DWACC(32), .SIGNED(1'b0), .SAT(1'b1)) u0 (.clk(clk), .rst(rst), .bus(b0));
  npu_cube_acc_resolve #(.DWIN(19), .DWACC(32), .SIGNED(1'b1), .SAT(1'b1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  npu_cube_acc_resolve #(.DWIN(19), .DWACC(20), .SIGNED(1'b0), .SAT(1'b1)) u2 (.clk(clk), .rst(rst), .bus(b2));
  npu_cube_acc_resolve #(.DWIN(19), .DWACC(20), .SIGNED(1'b0), .SAT(1'b0)) u3 (.clk(clk), .rst(rst), .bus(b3));
  npu_cube_acc_resolve #(.DWIN(19), .DWACC(20), .SIGNED(1'b1), .SAT(1'b1)) u4 (.clk(clk), .rst(rst), .bus(b4));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      m_acc[k] = 0;
      m_ovf[k] = 1'b0;
    end
  endtask

  // Arithmetic model: value ranges checked on plain integers.
  task automatic model_beat(input logic [18:0] s, input logic [18:0] c, input bit f, input bit l);
    longint r, e, nv, lo, hi, msk;
    bit     o;
    exp_t   x;
    x = '0;
    r = (longint'(s) + 2 * longint'(c)) % 524288;
    m_cnt = f ? 1 : ((m_cnt >= 65535) ? 65535 : m_cnt + 1);
    for (int k = 0; k < 5; k++) begin
      msk = (longint'(1) <<< cw[k]) - 1;
      e   = (cs[k] && r >= 262144) ? r - 524288 : r;
      lo  = cs[k] ? -(longint'(1) <<< (cw[k] - 1)) : 0;
      hi  = cs[k] ? (longint'(1) <<< (cw[k] - 1)) - 1 : msk;
      nv  = (f ? 0 : m_acc[k]) + e;
      o   = (nv < lo) || (nv > hi);
      if (o) begin
        if (cz[k]) nv = (nv < lo) ? lo : hi;
        else begin
          nv = nv & msk;
          if (cs[k] && nv > hi) nv = nv - (msk + 1);
        end
      end
      m_ovf[k] = (f ? 1'b0 : m_ovf[k]) | o;
      m_acc[k] = nv;
      x.d[k]   = 32'(nv & msk);
      x.o[k]   = m_ovf[k];
    end
    x.c = 16'(m_cnt);
    if (l) begin
      exp_q.push_back(x);
      model_reset();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat, bounded wait for acceptance; returns 1ns after the accept edge.
  task automatic send_beat(input logic [18:0] s, input logic [18:0] c, input bit f, input bit l);
    int n = 0;
    bit done = 1'b0;
    in_valid = 1'b1; in_sum = s; in_cay = c; in_first = f; in_last = l;
    while (!done) begin
      @(negedge clk);
      if (b0.in_ready) begin
        model_beat(s, c, f, l);
        done = 1'b1;
      end else if (++n > 100) begin
        checks++; errors++;
        $display("FAIL accept_timeout: beat not accepted after %0d cycles", n);
        done = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && b0.out_valid && b0.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: got out_data %0h expected no result", b0.out_data);
      end else begin
        e = exp_q.pop_front();
        chk("data_u32",     64'(b0.out_data), 64'(e.d[0]));
        chk("data_s32",     64'(b1.out_data), 64'(e.d[1]));
        chk("data_u20sat",  64'(b2.out_data), 64'(e.d[2]));
        chk("data_u20wrap", 64'(b3.out_data), 64'(e.d[3]));
        chk("data_s20sat",  64'(b4.out_data), 64'(e.d[4]));
        chk("cnt_u32",      64'(b0.out_cnt),  64'(e.c));
        chk("cnt_s20sat",   64'(b4.out_cnt),  64'(e.c));
        chk("ovf_u32",      64'(b0.out_ovf),  64'(e.o[0]));
        chk("ovf_s32",      64'(b1.out_ovf),  64'(e.o[1]));
        chk("ovf_u20sat",   64'(b2.out_ovf),  64'(e.o[2]));
        chk("ovf_u20wrap",  64'(b3.out_ovf),  64'(e.o[3]));
        chk("ovf_s20sat",   64'(b4.out_ovf),  64'(e.o[4]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int vcnt;
    int len;
    bit nofirst;
    logic [18:0] s, c;
    model_reset();
    #1;
    chk("reset_in_ready",  64'(b0.in_ready),  64'd1);
    chk("reset_out_valid", 64'(b0.out_valid), 64'd0);
    chk("reset_out_data",  64'(b0.out_data),  64'd0);
    chk("reset_out_cnt",   64'(b0.out_cnt),   64'd0);
    chk("reset_out_ovf",   64'(b0.out_ovf),   64'd0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // one-beat burst: 5 + 2*3 = 11, result visible after the second edge
    send_beat(19'd5, 19'd3, 1'b1, 1'b1);
    @(negedge clk);
    chk("t1_valid_early", 64'(b0.out_valid), 64'd0);
    @(negedge clk);
    chk("t1_valid_late",  64'(b0.out_valid), 64'd1);
    repeat (3) tick();

    // four beats of 100, result valid for exactly one cycle
    for (int i = 0; i < 4; i++) send_beat(19'd100, 19'd0, i == 0, i == 3);
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (b0.out_valid) vcnt++;
    end
    chk("t2_valid_cycles", 64'(vcnt), 64'd1);
    tick();

    // signed -3 then +1; unsigned saturation / wrap with three maximal beats
    send_beat(19'h7FFFD, 19'd0, 1'b1, 1'b0);
    send_beat(19'd1, 19'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send_beat(19'h7FFFF, 19'd0, i == 0, i == 2);
    // large negative signed beats drive the signed 20-bit copy into its min clamp
    for (int i = 0; i < 4; i++) send_beat(19'h40000, 19'd0, i == 0, i == 3);
    repeat (5) tick();

    // back-pressure: second one-beat burst stalls in S1 behind the held result
    rdy_mode = 1;
    repeat (2) tick();
    send_beat(19'd3, 19'd1, 1'b1, 1'b1);
    send_beat(19'd4, 19'd2, 1'b1, 1'b1);
    repeat (3) tick();
    @(negedge clk);
    chk("t4_in_ready_stall", 64'(b0.in_ready),  64'd0);
    chk("t4_out_held",       64'(b0.out_valid), 64'd1);
    rdy_mode = 0;
    repeat (8) tick();

    // reset mid-burst with a result pending
    rdy_mode = 1;
    repeat (2) tick();
    send_beat(19'd7, 19'd0, 1'b1, 1'b1);
    send_beat(19'd1, 19'd0, 1'b1, 1'b0);
    send_beat(19'd2, 19'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    chk("t6_out_valid", 64'(b0.out_valid), 64'd0);
    chk("t6_out_data",  64'(b0.out_data),  64'd0);
    chk("t6_out_cnt",   64'(b0.out_cnt),   64'd0);
    chk("t6_in_ready",  64'(b0.in_ready),  64'd1);
    exp_q.delete();
    model_reset();
    rdy_mode = 0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    send_beat(19'd10, 19'd0, 1'b0, 1'b0);
    send_beat(19'd20, 19'd0, 1'b0, 1'b1);
    repeat (4) tick();

    // randomized bursts under random back-pressure
    rdy_mode = 2;
    for (int b = 0; b < 60; b++) begin
      len = $urandom_range(1, 6);
      nofirst = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          s = 19'h7FFFF - 19'($urandom_range(0, 15));
          c = 19'($urandom_range(0, 3));
        end else begin
          s = 19'($urandom);
          c = 19'($urandom);
        end
        send_beat(s, c, (i == 0) && !nofirst, i == len - 1);
        if ($urandom_range(0, 3) == 0) tick();
      end
    end
    rdy_mode = 0;
    repeat (20) tick();
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
